// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the bit-serial ALU.
package alu_pkg;

    localparam logic [2:0] ALU_MOV = 3'b000;
    localparam logic [2:0] ALU_NOT = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_AND = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b110;
    localparam logic [2:0] ALU_ILL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    function automatic logic is_subtract(input logic [2:0] sel);
        return (sel == ALU_SUB) || (sel == ALU_SLT);
    endfunction

endpackage

// File: rtl/alu_slice.sv
// One-bit ALU slice: full adder plus bitwise logic, selected by opcode.
module alu_slice
    import alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       c_in,
    input  logic [2:0] select,
    output logic       r,
    output logic       c_out
);

    logic b_eff;
    logic sum;
    logic carry;

    // Subtraction and compare run as a + ~b + 1; the +1 comes from the preset carry.
    assign b_eff = is_subtract(select) ? ~b : b;
    assign sum   = a ^ b_eff ^ c_in;
    assign carry = (a & b_eff) | (c_in & (a ^ b_eff));

    always_comb begin
        r     = 1'b0;
        c_out = 1'b0;
        case (select)
            ALU_MOV: r = a;
            ALU_NOT: r = ~a;
            ALU_ADD, ALU_SUB, ALU_SLT: begin
                r     = sum;
                c_out = carry;
            end
            ALU_OR:  r = a | b;
            ALU_AND: r = a & b;
            default: r = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU controller: latches a request, runs one slice per cycle LSB first,
// then presents a one-cycle response.
module alu_serial_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             resp_valid,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             op_err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_out_q, carry_out_d;
    logic             op_err_q, op_err_d;
    logic             resp_valid_q, resp_valid_d;

    logic             slice_r;
    logic             slice_c;
    logic [WIDTH-1:0] acc_shift;

    alu_slice u_slice (
        .a      (acc_q[0]),
        .b      (b_q[0]),
        .c_in   (carry_q),
        .select (op_q),
        .r      (slice_r),
        .c_out  (slice_c)
    );

    // Operand A shifts out at the bottom while result bits enter at the top,
    // so after WIDTH cycles the same register holds the full result.
    assign acc_shift = {slice_r, acc_q[WIDTH-1:1]};

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        acc_d        = acc_q;
        b_d          = b_q;
        carry_d      = carry_q;
        cnt_d        = cnt_q;
        result_d     = result_q;
        carry_out_d  = carry_out_q;
        op_err_d     = op_err_q;
        resp_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_RUN;
                    op_d    = op;
                    acc_d   = a;
                    b_d     = b;
                    cnt_d   = '0;
                    carry_d = is_subtract(op);
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d   = acc_shift;
                    b_d     = b_q >> 1;
                    carry_d = slice_c;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        state_d      = ST_DONE;
                        resp_valid_d = 1'b1;
                        op_err_d     = (op_q == ALU_ILL);
                        carry_out_d  = (op_q == ALU_ADD || op_q == ALU_SUB) ? slice_c : 1'b0;
                        case (op_q)
                            // Signed less-than: N xor V, with V from carry into and out of the MSB.
                            ALU_SLT: result_d = WIDTH'(slice_r ^ carry_q ^ slice_c);
                            ALU_ILL: result_d = '0;
                            default: result_d = acc_shift;
                        endcase
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op_q         <= ALU_MOV;
            acc_q        <= '0;
            b_q          <= '0;
            carry_q      <= 1'b0;
            cnt_q        <= '0;
            result_q     <= '0;
            carry_out_q  <= 1'b0;
            op_err_q     <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            acc_q        <= acc_d;
            b_q          <= b_d;
            carry_q      <= carry_d;
            cnt_q        <= cnt_d;
            result_q     <= result_d;
            carry_out_q  <= carry_out_d;
            op_err_q     <= op_err_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign result     = result_q;
    assign carry_out  = carry_out_q;
    assign op_err     = op_err_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed bench for alu_serial_ctrl at WIDTH=8 with hand-computed expectations.
module tb_alu_serial_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [2:0] op = 3'b000;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       abort = 1'b0;
    logic       resp_valid;
    logic [7:0] result;
    logic       carry_out;
    logic       op_err;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    alu_serial_ctrl #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .op         (op),
        .a          (a),
        .b          (b),
        .abort      (abort),
        .resp_valid (resp_valid),
        .result     (result),
        .carry_out  (carry_out),
        .op_err     (op_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Issues one request once req_ready is seen, then waits for resp_valid.
    // lat = cycles from the accepting edge to the response (0 on timeout).
    task automatic run_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                          output logic [7:0] r, output logic c, output logic e, output int lat);
        int guard;
        lat = 0; r = 8'hxx; c = 1'bx; e = 1'bx;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        op = o; a = x; b = y; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (resp_valid) begin
                lat = k; r = result; c = carry_out; e = op_err;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp got=%b exp=0", resp_valid); end
        total++; if (result !== 8'h00) begin bad++; $display("FAIL reset_result got=%h exp=00", result); end
        total++; if ({carry_out, op_err} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {carry_out, op_err}); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        logic [7:0] r; logic c, e; int lat;
        run_op(3'b010, 8'h7F, 8'h01, r, c, e, lat);
        total++; if (lat !== 9) begin bad++; $display("FAIL add_latency got=%0d exp=9", lat); end
        total++; if (r !== 8'h80 || c !== 1'b0) begin bad++; $display("FAIL add_7f_01 got=%h/%b exp=80/0", r, c); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL add_op_err got=%b exp=0", e); end
        @(posedge clk); #1;
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL add_pulse got=%b exp=0", resp_valid); end
        run_op(3'b010, 8'hFF, 8'h01, r, c, e, lat);
        total++; if (r !== 8'h00 || c !== 1'b1) begin bad++; $display("FAIL add_ff_01 got=%h/%b exp=00/1", r, c); end
    endtask

    task automatic test_sub();
        logic [7:0] r; logic c, e; int lat;
        run_op(3'b011, 8'h05, 8'h07, r, c, e, lat);
        total++; if (r !== 8'hFE || c !== 1'b0) begin bad++; $display("FAIL sub_05_07 got=%h/%b exp=fe/0", r, c); end
        run_op(3'b011, 8'h07, 8'h05, r, c, e, lat);
        total++; if (r !== 8'h02 || c !== 1'b1) begin bad++; $display("FAIL sub_07_05 got=%h/%b exp=02/1", r, c); end
    endtask

    task automatic test_slt();
        logic [7:0] r; logic c, e; int lat;
        run_op(3'b110, 8'h80, 8'h01, r, c, e, lat);
        total++; if (r !== 8'h01 || c !== 1'b0) begin bad++; $display("FAIL slt_80_01 got=%h/%b exp=01/0", r, c); end
        run_op(3'b110, 8'h01, 8'h80, r, c, e, lat);
        total++; if (r !== 8'h00) begin bad++; $display("FAIL slt_01_80 got=%h exp=00", r); end
        run_op(3'b110, 8'h7F, 8'h80, r, c, e, lat);
        total++; if (r !== 8'h00) begin bad++; $display("FAIL slt_7f_80 got=%h exp=00", r); end
        run_op(3'b110, 8'hFE, 8'hFF, r, c, e, lat);
        total++; if (r !== 8'h01) begin bad++; $display("FAIL slt_fe_ff got=%h exp=01", r); end
    endtask

    task automatic test_logic();
        logic [7:0] r; logic c, e; int lat;
        run_op(3'b100, 8'hA5, 8'h0F, r, c, e, lat);
        total++; if (r !== 8'hAF || c !== 1'b0) begin bad++; $display("FAIL or_a5_0f got=%h/%b exp=af/0", r, c); end
        run_op(3'b101, 8'hA5, 8'h0F, r, c, e, lat);
        total++; if (r !== 8'h05) begin bad++; $display("FAIL and_a5_0f got=%h exp=05", r); end
        run_op(3'b001, 8'hA5, 8'h0F, r, c, e, lat);
        total++; if (r !== 8'h5A) begin bad++; $display("FAIL not_a5 got=%h exp=5a", r); end
        run_op(3'b000, 8'hA5, 8'h0F, r, c, e, lat);
        total++; if (r !== 8'hA5 || c !== 1'b0) begin bad++; $display("FAIL mov_a5 got=%h/%b exp=a5/0", r, c); end
    endtask

    task automatic test_illegal();
        logic [7:0] r; logic c, e; int lat;
        run_op(3'b111, 8'hFF, 8'hFF, r, c, e, lat);
        total++; if (lat !== 9) begin bad++; $display("FAIL ill_latency got=%0d exp=9", lat); end
        total++; if (r !== 8'h00 || c !== 1'b0 || e !== 1'b1) begin
            bad++; $display("FAIL ill_outputs got=%h/%b/%b exp=00/0/1", r, c, e);
        end
    endtask

    task automatic test_back_to_back();
        int c0, acc2, n;
        int resp_cyc [2];
        logic [7:0] resp_res [2];
        logic acc_now;
        acc2 = -1; n = 0;
        while (!req_ready) begin @(posedge clk); #1; end
        op = 3'b010; a = 8'h01; b = 8'h02; req_valid = 1'b1;
        @(posedge clk); #1;
        c0 = cyc;
        req_valid = 1'b0;
        @(posedge clk); #1;
        op = 3'b011; a = 8'h09; b = 8'h03; req_valid = 1'b1;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_in_run got=%b exp=0", req_ready); end
        for (int k = 0; k < 40 && n < 2; k++) begin
            acc_now = req_valid && req_ready;
            @(posedge clk); #1;
            if (acc_now) begin req_valid = 1'b0; acc2 = cyc; end
            if (resp_valid) begin resp_cyc[n] = cyc; resp_res[n] = result; n++; end
        end
        req_valid = 1'b0;
        total++; if (n !== 2) begin bad++; $display("FAIL b2b_resp_count got=%0d exp=2", n); end
        else begin
            total++; if (acc2 - c0 !== 10) begin bad++; $display("FAIL b2b_accept_gap got=%0d exp=10", acc2 - c0); end
            total++; if (resp_cyc[1] - resp_cyc[0] !== 10) begin
                bad++; $display("FAIL b2b_resp_gap got=%0d exp=10", resp_cyc[1] - resp_cyc[0]);
            end
            total++; if (resp_res[0] !== 8'h03 || resp_res[1] !== 8'h06) begin
                bad++; $display("FAIL b2b_results got=%h,%h exp=03,06", resp_res[0], resp_res[1]);
            end
        end
    endtask

    task automatic test_abort();
        logic [7:0] r; logic c, e; int lat, seen;
        run_op(3'b000, 8'h3C, 8'h00, r, c, e, lat);
        @(posedge clk); #1;
        op = 3'b010; a = 8'h11; b = 8'h22; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL abort_to_idle got=%b exp=1", req_ready); end
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (resp_valid) seen++;
            @(posedge clk); #1;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL abort_no_resp got=%0d exp=0", seen); end
        total++; if (result !== 8'h3C) begin bad++; $display("FAIL abort_result_kept got=%h exp=3c", result); end
        // Abort while idle must not block the request.
        op = 3'b101; a = 8'hF0; b = 8'h3C; req_valid = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; abort = 1'b0;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL abort_idle_accept got=%b exp=0", req_ready); end
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            if (resp_valid) begin lat = k; r = result; break; end
            @(posedge clk); #1;
        end
        total++; if (lat !== 9 || r !== 8'h30) begin bad++; $display("FAIL abort_idle_op got=%0d/%h exp=9/30", lat, r); end
    endtask

    task automatic test_reset_mid_run();
        int seen;
        @(posedge clk); #1;
        op = 3'b100; a = 8'h0F; b = 8'hF0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            bad++; $display("FAIL rst_run_ctrl got=%b/%b exp=1/0", req_ready, resp_valid);
        end
        total++; if (result !== 8'h00 || carry_out !== 1'b0 || op_err !== 1'b0) begin
            bad++; $display("FAIL rst_run_outputs got=%h/%b/%b exp=00/0/0", result, carry_out, op_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (resp_valid) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL rst_run_no_resp got=%0d exp=0", seen); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_slt();
        test_logic();
        test_illegal();
        test_back_to_back();
        test_abort();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
